// File: rtl/div8_8_if.sv
// div8_8_if: start/done handshake and operand/result bus of the signed divider.
interface div8_8_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
    modport master (output start, a, b, input busy, done, q, r, dz);
    modport slave  (input start, a, b, output busy, done, q, r, dz);
endinterface

// File: rtl/div8_8.sv
// div8_8: sequential signed radix-2 restoring divider, one quotient bit per clock, C-style truncation.
module div8_8 #(parameter int WIDTH = 8) (
    input  logic     clk,
    input  logic     rst_n,
    div8_8_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, LOAD, CALC, FIX} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, babs_q, babs_d, dvd_q, dvd_d, rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
    logic [WIDTH:0]   rem_sh, trial;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sq_q, sq_d, sr_q, sr_d, dz_q, dz_d, done_q, done_d;
    logic             accept;
    // done is registered out of FIX, so busy stays high through the done cycle
    assign accept   = state_q == IDLE && !done_q && bus.start;
    assign rem_sh   = {rem_q, dvd_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, babs_q};
    assign bus.busy = state_q != IDLE || done_q;
    assign bus.done = done_q;
    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.dz   = dz_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        babs_d  = babs_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = LOAD;
                a_d     = bus.a;
                sq_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                sr_d    = bus.a[WIDTH-1];
                dvd_d   = bus.a[WIDTH-1] ? -bus.a : bus.a;
                babs_d  = bus.b[WIDTH-1] ? -bus.b : bus.b;
            end
            LOAD: begin
                rem_d   = '0;
                cnt_d   = CW'(WIDTH - 1);
                state_d = CALC;
            end
            CALC: begin
                rem_d   = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                dvd_d   = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == '0 ? FIX : CALC;
            end
            FIX: begin
                dz_d    = babs_q == '0;
                q_d     = babs_q == '0 ? '1 : sq_q ? -dvd_q : dvd_q;
                r_d     = babs_q == '0 ? a_q : sr_q ? -rem_q : rem_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            babs_q  <= '0;
            dvd_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            babs_q  <= babs_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_div8_8.sv
// tb_div8_8: table-driven vectors plus scoreboard of random signed divisions against a C-semantics model.
module tb_div8_8;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    div8_8_if #(.WIDTH(W)) bus();
    div8_8 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    typedef struct {logic [W-1:0] a, b, q, r; logic dz;} vec_t;
    typedef struct {logic [W-1:0] q, r; logic dz; int e0; int tag;} exp_t;
    exp_t sb[$];
    exp_t got;
    vec_t tbl[10];
    int checks = 0;
    int failures = 0;
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;
    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s #%0d: got %0h expected %0h", nm, tag, act, exp);
        end
    endtask
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int tag);
        exp_t e;
        int sa, sd;
        sa = int'($signed(a));
        sd = int'($signed(b));
        e.tag = tag;
        e.e0 = 0;
        if (sd == 0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
        end else begin
            e.q = W'(sa / sd); e.r = W'(sa % sd); e.dz = 1'b0;
        end
        return e;
    endfunction
    // result monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_done", 0, 1, 0);
            else begin
                got = sb.pop_front();
                chk("q", got.tag, bus.q, got.q);
                chk("r", got.tag, bus.r, got.r);
                chk("dz", got.tag, bus.dz, got.dz);
                chk("latency", got.tag, edge_n - got.e0, 10);
            end
        end
    end
    // call at a negedge; returns at the negedge after the accepting edge
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e, input bit hold);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", e.tag, 1, 0);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        e.e0 = edge_n;
        sb.push_back(e);
        chk("busy_rise", e.tag, bus.busy, 1);
        if (!hold) bus.start = 1'b0;
    endtask
    task automatic wait_done(input int tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.done !== 1'b1 && n < 30);
        if (n >= 30) chk("done_timeout", tag, 1, 0);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        exp_t e;
        logic [W-1:0] ra, rb;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        tbl[0] = '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0};
        tbl[1] = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0};
        tbl[2] = '{8'h64, 8'hF9, 8'hF2, 8'h02, 1'b0};
        tbl[3] = '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0};
        tbl[4] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0};
        tbl[5] = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0};
        tbl[6] = '{8'h05, 8'h09, 8'h00, 8'h05, 1'b0};
        tbl[7] = '{8'h00, 8'h03, 8'h00, 8'h00, 1'b0};
        tbl[8] = '{8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1};
        tbl[9] = '{8'h06, 8'h03, 8'h02, 8'h00, 1'b0};
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, bus.busy, 0);
        chk("rst_done", 0, bus.done, 0);
        chk("rst_q", 0, bus.q, 0);
        chk("rst_r", 0, bus.r, 0);
        chk("rst_dz", 0, bus.dz, 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            e.q = tbl[i].q; e.r = tbl[i].r; e.dz = tbl[i].dz; e.tag = i; e.e0 = 0;
            issue(tbl[i].a, tbl[i].b, e, 1'b0);
            wait_done(i);
        end
        // starts while busy are ignored
        e.q = 8'h0E; e.r = 8'h02; e.dz = 1'b0; e.tag = 100;
        issue(8'h64, 8'h07, e, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h32; bus.b = 8'h03;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h05;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(100);
        // start held from the done cycle: ignored there, accepted after one idle cycle
        bus.start = 1'b1; bus.a = 8'h06; bus.b = 8'h03;
        @(negedge clk);
        chk("held_busy_low", 101, bus.busy, 0);
        @(negedge clk);
        chk("held_busy_rise", 101, bus.busy, 1);
        e.q = 8'h02; e.r = 8'h00; e.dz = 1'b0; e.tag = 101; e.e0 = edge_n;
        sb.push_back(e);
        bus.start = 1'b0;
        wait_done(101);
        // reset in the middle of CALC aborts without a done pulse
        e.q = 8'h0E; e.r = 8'h02; e.dz = 1'b0; e.tag = 102;
        issue(8'h64, 8'h07, e, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 102, bus.busy, 0);
        chk("abort_done", 102, bus.done, 0);
        chk("abort_q", 102, bus.q, 0);
        chk("abort_r", 102, bus.r, 0);
        chk("abort_dz", 102, bus.dz, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_idle", 102, bus.busy, 0);
        e.q = 8'h0E; e.r = 8'hFE; e.dz = 1'b0; e.tag = 103;
        issue(8'h9C, 8'hF9, e, 1'b0);
        wait_done(103);
        for (int i = 0; i < 300; i++) begin
            ra = W'($urandom);
            rb = (i % 25 == 0) ? '0 : W'($urandom);
            issue(ra, rb, model(ra, rb, 1000 + i), 1'b0);
            wait_done(1000 + i);
        end
        repeat (2) @(negedge clk);
        chk("sb_drained", 0, sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
